// File: rtl/mix_columns_seq_if.sv
// Valid/ready bundle carrying one 128-bit AES state into and out of the
// forward MixColumns engine.
interface mix_columns_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_bypass;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output in_bypass,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_bypass,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/mix_columns_seq.sv
// Forward AES MixColumns engine: transforms a latched state in place,
// COLS_PER_CYCLE columns per BUSY cycle, with a per-state bypass for the final round.
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    mix_columns_seq_if.slave  bus
);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_param
            $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] CNT_LAST = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg;
    logic [1:0]        cnt_reg;
    logic              bypass_reg;
    logic              in_ready_reg;
    logic              out_valid_reg;
    // Column 0 sits in the most significant word, matching the bus layout.
    logic [0:3][31:0]  col_reg;

    logic [1:0]        lane_idx [COLS_PER_CYCLE];
    logic [31:0]       lane_col [COLS_PER_CYCLE];
    logic [31:0]       lane_res [COLS_PER_CYCLE];

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        // 3x is folded in as xtime(x) ^ x.
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    generate
        for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_lane
            assign lane_idx[gi] = cnt_reg + 2'(gi);
            assign lane_col[gi] = col_reg[lane_idx[gi]];
            assign lane_res[gi] = bypass_reg ? lane_col[gi] : mix_column(lane_col[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= 2'd0;
            bypass_reg    <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            col_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid && in_ready_reg) begin
                        col_reg      <= bus.in_data;
                        bypass_reg   <= bus.in_bypass;
                        cnt_reg      <= 2'd0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= BUSY;
                    end
                end
                BUSY: begin
                    for (int l = 0; l < COLS_PER_CYCLE; l++) begin
                        col_reg[lane_idx[l]] <= lane_res[l];
                    end
                    cnt_reg <= cnt_reg + CNT_STEP;
                    if (cnt_reg == CNT_LAST) begin
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    // in_ready comes from a register, so out_ready never reaches it combinationally.
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    // Gating with out_valid keeps partial results and post-reset garbage off the bus.
    assign bus.out_data  = out_valid_reg ? col_reg : 128'd0;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed and round-trip bench for mix_columns_seq at COLS_PER_CYCLE = 1, 2 and 4.
module tb_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   in_valid_v;
    logic [2:0]   out_ready_v;
    logic [127:0] in_data;
    logic         in_bypass;
    logic [2:0]   in_ready_v;
    logic [2:0]   out_valid_v;
    logic [127:0] out_data_a [3];

    int vectors     = 0;
    int miscompares = 0;
    int n_in        = 0;
    int n_out       = 0;

    always #5 clk = ~clk;

    mix_columns_seq_if if_c1 ();
    mix_columns_seq_if if_c2 ();
    mix_columns_seq_if if_c4 ();

    assign if_c1.in_valid  = in_valid_v[0];
    assign if_c2.in_valid  = in_valid_v[1];
    assign if_c4.in_valid  = in_valid_v[2];
    assign if_c1.out_ready = out_ready_v[0];
    assign if_c2.out_ready = out_ready_v[1];
    assign if_c4.out_ready = out_ready_v[2];
    assign if_c1.in_data   = in_data;
    assign if_c2.in_data   = in_data;
    assign if_c4.in_data   = in_data;
    assign if_c1.in_bypass = in_bypass;
    assign if_c2.in_bypass = in_bypass;
    assign if_c4.in_bypass = in_bypass;

    assign in_ready_v    = {if_c4.in_ready, if_c2.in_ready, if_c1.in_ready};
    assign out_valid_v   = {if_c4.out_valid, if_c2.out_valid, if_c1.out_valid};
    assign out_data_a[0] = if_c1.out_data;
    assign out_data_a[1] = if_c2.out_data;
    assign out_data_a[2] = if_c4.out_data;

    mix_columns_seq #(.COLS_PER_CYCLE(1)) dut_c1 (.clk(clk), .rst_n(rst_n), .bus(if_c1.slave));
    mix_columns_seq #(.COLS_PER_CYCLE(2)) dut_c2 (.clk(clk), .rst_n(rst_n), .bus(if_c2.slave));
    mix_columns_seq #(.COLS_PER_CYCLE(4)) dut_c4 (.clk(clk), .rst_n(rst_n), .bus(if_c4.slave));

    // Handshake counters for the COLS_PER_CYCLE=4 instance used in the round-trip run.
    always @(posedge clk) begin
        if (rst_n) begin
            if (in_valid_v[2] && in_ready_v[2])   n_in  <= n_in + 1;
            if (out_valid_v[2] && out_ready_v[2]) n_out <= n_out + 1;
        end
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9);
            r[119-32*c -: 8] = gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13);
            r[111-32*c -: 8] = gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11);
            r[103-32*c -: 8] = gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14);
        end
        return r;
    endfunction

    // Drives one transaction into instance k; lat counts edges from acceptance to out_valid.
    task automatic run_txn(input int k, input logic [127:0] data, input logic byp, input int rdly,
                           output logic [127:0] got, output int lat);
        int w;
        got = '0;
        lat = -1;
        @(negedge clk);
        in_data       = data;
        in_bypass     = byp;
        in_valid_v[k] = 1'b1;
        w = 0;
        while (!in_ready_v[k] && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready_v[k]) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout inst%0d: in_ready=0 required 1", k);
            in_valid_v[k] = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid_v[k] = 1'b0;
        in_data       = '0;
        w = 0;
        while (!out_valid_v[k] && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!out_valid_v[k]) begin
            vectors++;
            miscompares++;
            $display("FAIL result_timeout inst%0d: out_valid=0 required 1", k);
            return;
        end
        lat = w;
        repeat (rdly) @(negedge clk);
        got            = out_data_a[k];
        out_ready_v[k] = 1'b1;
        @(negedge clk);
        out_ready_v[k] = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (in_ready_v[k] !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_in_ready inst%0d: got %b required 1", k, in_ready_v[k]);
            end
            vectors++;
            if (out_valid_v[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_out_valid inst%0d: got %b required 0", k, out_valid_v[k]);
            end
            vectors++;
            if (out_data_a[k] !== 128'd0) begin
                miscompares++;
                $display("FAIL reset_out_data inst%0d: got %h required 0", k, out_data_a[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset: checked idle outputs of 3 instances");
    endtask

    task automatic test_fips();
        logic [127:0] got;
        int lat;
        run_txn(0, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 0, got, lat);
        vectors++;
        if (got !== 128'h046681e5e0cb199a48f8d37a2806264c) begin
            miscompares++;
            $display("FAIL fips_data: got %h required 046681e5e0cb199a48f8d37a2806264c", got);
        end
        vectors++;
        if (lat !== 4) begin
            miscompares++;
            $display("FAIL fips_latency: got %0d required 4", lat);
        end
        $display("fips c1: out=%h lat=%0d", got, lat);
    endtask

    task automatic test_known_cols();
        logic [127:0] got;
        int lat;
        int exp_lat [3] = '{0, 2, 1};
        for (int k = 2; k >= 1; k--) begin
            run_txn(k, 128'hdb135345f20a225c01010101c6c6c6c6, 1'b0, 0, got, lat);
            vectors++;
            if (got !== 128'h8e4da1bc9fdc589d01010101c6c6c6c6) begin
                miscompares++;
                $display("FAIL known_data inst%0d: got %h required 8e4da1bc9fdc589d01010101c6c6c6c6", k, got);
            end
            vectors++;
            if (lat !== exp_lat[k]) begin
                miscompares++;
                $display("FAIL known_latency inst%0d: got %0d required %0d", k, lat, exp_lat[k]);
            end
            $display("known inst%0d: out=%h lat=%0d", k, got, lat);
        end
    endtask

    task automatic test_bypass();
        logic [127:0] got;
        int lat;
        run_txn(0, 128'hd4d4d4d52d26314c00000000ffffffff, 1'b1, 0, got, lat);
        vectors++;
        if (got !== 128'hd4d4d4d52d26314c00000000ffffffff) begin
            miscompares++;
            $display("FAIL bypass_data: got %h required d4d4d4d52d26314c00000000ffffffff", got);
        end
        vectors++;
        if (lat !== 4) begin
            miscompares++;
            $display("FAIL bypass_latency: got %0d required 4", lat);
        end
        $display("bypass=1 c1: out=%h lat=%0d", got, lat);
        run_txn(0, 128'hd4d4d4d52d26314c00000000ffffffff, 1'b0, 0, got, lat);
        vectors++;
        if (got !== 128'hd5d5d7d64d7ebdf800000000ffffffff) begin
            miscompares++;
            $display("FAIL nobypass_data: got %h required d5d5d7d64d7ebdf800000000ffffffff", got);
        end
        $display("bypass=0 c1: out=%h lat=%0d", got, lat);
    endtask

    task automatic test_backpressure();
        int w;
        @(negedge clk);
        in_data        = 128'hdb135345f20a225c01010101c6c6c6c6;
        in_bypass      = 1'b0;
        in_valid_v[1]  = 1'b1;
        out_ready_v[1] = 1'b0;
        @(negedge clk);
        in_valid_v[1] = 1'b0;
        w = 0;
        while (!out_valid_v[1] && w < 20) begin
            @(negedge clk);
            w++;
        end
        for (int i = 0; i < 10; i++) begin
            in_valid_v[1] = i[0];
            in_data       = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            vectors++;
            if (out_valid_v[1] !== 1'b1 || in_ready_v[1] !== 1'b0 ||
                out_data_a[1] !== 128'h8e4da1bc9fdc589d01010101c6c6c6c6) begin
                miscompares++;
                $display("FAIL hold cycle%0d: valid=%b ready=%b data=%h required 1 0 8e4da1bc9fdc589d01010101c6c6c6c6",
                         i, out_valid_v[1], in_ready_v[1], out_data_a[1]);
            end
        end
        in_valid_v[1]  = 1'b0;
        out_ready_v[1] = 1'b1;
        @(negedge clk);
        out_ready_v[1] = 1'b0;
        vectors++;
        if (out_valid_v[1] !== 1'b0 || in_ready_v[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL release: valid=%b ready=%b required 0 1", out_valid_v[1], in_ready_v[1]);
        end
        repeat (6) @(negedge clk);
        vectors++;
        if (out_valid_v[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL ghost_result: out_valid=%b required 0", out_valid_v[1]);
        end
        $display("backpressure c2: held 10 cycles then released");
    endtask

    task automatic test_reset_mid();
        logic [127:0] got;
        int lat;
        @(negedge clk);
        in_data       = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
        in_bypass     = 1'b0;
        in_valid_v[0] = 1'b1;
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid_v[0] !== 1'b0 || out_data_a[0] !== 128'd0 || in_ready_v[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset: valid=%b data=%h ready=%b required 0 0 1",
                     out_valid_v[0], out_data_a[0], in_ready_v[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        vectors++;
        if (out_valid_v[0] !== 1'b0 || out_data_a[0] !== 128'd0) begin
            miscompares++;
            $display("FAIL stale_after_reset: valid=%b data=%h required 0 0", out_valid_v[0], out_data_a[0]);
        end
        run_txn(0, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 0, got, lat);
        vectors++;
        if (got !== 128'h046681e5e0cb199a48f8d37a2806264c || lat !== 4) begin
            miscompares++;
            $display("FAIL post_reset_txn: got %h lat %0d required 046681e5e0cb199a48f8d37a2806264c lat 4", got, lat);
        end
        $display("reset mid-busy c1: recovered out=%h", got);
    endtask

    task automatic test_random_roundtrip();
        logic [127:0] data;
        logic [127:0] got;
        int lat;
        int base_in;
        int base_out;
        int bad = 0;
        base_in  = n_in;
        base_out = n_out;
        for (int i = 0; i < 10000; i++) begin
            data = {$urandom, $urandom, $urandom, $urandom};
            repeat ($urandom_range(0, 1)) @(negedge clk);
            run_txn(2, data, 1'b0, $urandom_range(0, 1), got, lat);
            vectors++;
            if (inv_mix(got) !== data) begin
                miscompares++;
                bad++;
                $display("FAIL roundtrip #%0d: recovered %h required %h", i, inv_mix(got), data);
            end
        end
        vectors++;
        if ((n_in - base_in) !== 10000 || (n_out - base_out) !== (n_in - base_in)) begin
            miscompares++;
            $display("FAIL txn_count: in %0d out %0d required 10000 10000", n_in - base_in, n_out - base_out);
        end
        $display("random roundtrip c4: 10000 states, %0d bad, in=%0d out=%0d",
                 bad, n_in - base_in, n_out - base_out);
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid_v  = '0;
        out_ready_v = '0;
        in_data     = '0;
        in_bypass   = 1'b0;
        test_reset();
        test_fips();
        test_known_cols();
        test_bypass();
        test_backpressure();
        test_reset_mid();
        test_random_roundtrip();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
